io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter IO_ADDR, default 7'h7F: word address decoded as the I/O register.
REQ-002 Parameter DIV_BITS, default 16: width of the display refresh divider.
REQ-003 CLK  input  1  system clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CS  input  1  CPU chip select.
REQ-006 WE  input  1  CPU write enable.
REQ-007 ADDR  input  7  CPU word address.
REQ-008 Mem_Bus  inout  32  shared CPU/memory data bus.
REQ-009 MEM_CS  output  1  chip select forwarded to the RAM.
REQ-010 SW  input  8  asynchronous slide switches.
REQ-011 LED  output  8  mirror of I/O register bits [7:0].
REQ-012 SEG  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-013 AN  output  4  active-low digit enables, one-hot-low.

Function
REQ-014 io_hit SHALL be (ADDR == IO_ADDR); the decode is combinational.
REQ-015 MEM_CS SHALL be CS & ~io_hit, so RAM never sees I/O accesses; RAM word IO_ADDR is unreachable.
REQ-016 Write: on posedge CLK with CS & WE & io_hit, out_reg[31:0] SHALL load Mem_Bus; it holds otherwise.
REQ-017 SW SHALL pass through a 2-flop synchronizer; sw_sync lags SW by 2 posedges.
REQ-018 Read capture: on posedge CLK with CS & ~WE & io_hit, rd_reg SHALL load {24'b0, sw_sync}.
REQ-019 The block SHALL drive Mem_Bus with rd_reg while CS & ~WE & io_hit, and SHALL leave it high-Z otherwise.
REQ-020 For a two-cycle CPU load (address cycle, then data cycle with CS held), the data cycle SHALL present rd_reg captured at the end of the address cycle; load-to-data latency is 1 cycle.
REQ-021 CS & WE & io_hit SHALL never drive the bus. No read capture is simultaneous with that write, because WE qualifies both.
REQ-022 LED SHALL equal out_reg[7:0] combinationally from the register.
REQ-023 Refresh divider: a DIV_BITS-bit counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-024 Scan FSM: four states D0..D3, advancing D0->D1->D2->D3->D0 on each divider wrap (tick) and holding otherwise.
REQ-025 In Dn, AN SHALL have bit n low and the others high, and SEG SHALL show the hex nibble out_reg[4n+3:4n].
REQ-026 Hex decode SHALL be standard active-low 0-F; for example 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
REQ-027 AN and SEG SHALL be registered: updated on the posedge after the state/nibble change, with 1 cycle latency.
REQ-028 An out_reg write mid-scan SHALL take effect on the current digit from the next registered update, without restarting the scan.

Reset
REQ-029 With RST high at posedge CLK, the block SHALL set out_reg=0, rd_reg=0, both sync flops=0, divider=0, scan state=D0, AN=4'b1110, and SEG=7'b1000000.
REQ-030 RST SHALL override a simultaneous I/O write; out_reg stays 0.
REQ-031 During and after reset, Mem_Bus drive follows REQ-019 only, with no reset-dependent drive; MEM_CS stays combinational.
REQ-032 Reset asserted mid-scan SHALL return the FSM to D0 and the divider to 0 on the same edge.

Verification
REQ-033 Write decode: CS=1, WE=1, ADDR=7'h7F, bus=32'h0000_A5C3, one posedge -> LED=8'hC3 and MEM_CS=0 throughout; ADDR=7'h10 with the same stimulus -> out_reg unchanged, MEM_CS=1.
REQ-034 Read path: SW=8'h5A held for 3 cycles, then CS=1, WE=0, ADDR=7'h7F for 2 cycles -> the bus reads 32'h0000_005A in the 2nd cycle, and the bus is Z when CS=0.
REQ-035 Synchronizer: SW changes 0->8'hFF one cycle before read capture -> the read returns 0; with the change 2 cycles before capture -> the read returns 8'hFF.
REQ-036 Scan (DIV_BITS=2): out_reg=32'h0000_1234 -> the AN sequence is 1110, 1101, 1011, 0111 every 4 cycles, with SEG showing 4, 3, 2, 1 (7'b0011001, 0110000, 0100100, 1111001).
REQ-037 Reset mid-operation: out_reg=32'hFFFF and scan at D2, then RST for 1 cycle coincident with an I/O write of 32'h1 -> out_reg=0, AN=1110, SEG=1000000.
REQ-038 Full-CPU integration: a program executes sw to 0x7F and then lw from 0x7F -> LED matches the stored byte, the destination register equals {24'b0, SW}, and RAM[127] is unchanged.

Source files
------------

// File: rtl/io_bridge.sv
// CPU-side I/O register bridge: decodes one word address as an I/O register
// that drives LEDs and a 4-digit seven-segment display and reads back the switches.
module io_bridge #(
    parameter logic [6:0] IO_ADDR  = 7'h7F,
    parameter int         DIV_BITS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WE,
    input  logic [6:0]  ADDR,
    inout  wire  [31:0] Mem_Bus,
    output logic        MEM_CS,
    input  logic [7:0]  SW,
    output logic [7:0]  LED,
    output logic [6:0]  SEG,
    output logic [3:0]  AN
);

    localparam logic [1:0] ST_D0 = 2'd0;
    localparam logic [1:0] ST_D1 = 2'd1;
    localparam logic [1:0] ST_D2 = 2'd2;
    localparam logic [1:0] ST_D3 = 2'd3;

    logic                io_hit;
    logic                wr_en;
    logic                rd_en;
    logic [31:0]         out_reg;
    logic [7:0]          rd_reg;
    logic [7:0]          sw_meta_reg;
    logic [7:0]          sw_sync_reg;
    logic [DIV_BITS-1:0] div_reg;
    logic                tick;
    logic [1:0]          state_reg;
    logic [1:0]          state_next;
    logic [3:0]          digit_nibble [4];
    logic [3:0]          cur_nibble;
    logic [3:0]          an_next;
    logic [6:0]          seg_next;
    logic [3:0]          an_reg;
    logic [6:0]          seg_reg;
    logic                unused_hi;

    // The I/O word is carved out of the RAM map: RAM never sees this address.
    assign io_hit = (ADDR == IO_ADDR);
    assign MEM_CS = CS & ~io_hit;
    assign wr_en  = CS & WE & io_hit;
    assign rd_en  = CS & ~WE & io_hit;

    assign Mem_Bus = rd_en ? {24'b0, rd_reg} : 32'bz;

    assign LED       = out_reg[7:0];
    assign unused_hi = ^out_reg[31:16];

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_reg <= 32'b0;
        end else if (wr_en) begin
            out_reg <= Mem_Bus;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta_reg <= 8'b0;
            sw_sync_reg <= 8'b0;
        end else begin
            sw_meta_reg <= SW;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // Captured during the address cycle so the data cycle sees a stable value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_reg <= 8'b0;
        end else if (rd_en) begin
            rd_reg <= sw_sync_reg;
        end
    end

    assign tick = &div_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_BITS'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                ST_D0:   state_next = ST_D1;
                ST_D1:   state_next = ST_D2;
                ST_D2:   state_next = ST_D3;
                ST_D3:   state_next = ST_D0;
                default: state_next = ST_D0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_D0;
        end else begin
            state_reg <= state_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [1:0] DIGIT = gi;
            assign digit_nibble[gi] = out_reg[4*gi +: 4];
            assign an_next[gi]      = (state_reg != DIGIT);
        end
    endgenerate

    assign cur_nibble = digit_nibble[state_reg];

    always_comb begin
        seg_next = 7'b1111111;
        case (cur_nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'b1111111;
        endcase
    end

    // Registered outputs keep the display pins glitch-free across state changes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            an_reg  <= 4'b1110;
            seg_reg <= 7'b1000000;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign AN  = an_reg;
    assign SEG = seg_reg;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed scenarios plus randomized traffic
// compared against a cycle-count based reference model and a small RAM model.
module tb_io_bridge;

    localparam int         DIV     = 2;
    localparam logic [6:0] IO_ADDR = 7'h7F;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CS = 1'b0;
    logic        WE = 1'b0;
    logic [6:0]  ADDR = 7'h0;
    logic [7:0]  SW = 8'h0;
    logic        MEM_CS;
    logic [7:0]  LED;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    wire  [31:0] Mem_Bus;

    logic        tb_en = 1'b0;
    logic [31:0] tb_data = 32'h0;
    logic [31:0] ram [128];
    logic        ram_en;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_cnt;
    logic [31:0] m_out;
    logic [7:0]  m_rd;
    logic [7:0]  m_sw1, m_sw2;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    io_bridge #(.IO_ADDR(IO_ADDR), .DIV_BITS(DIV)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR),
        .Mem_Bus(Mem_Bus), .MEM_CS(MEM_CS), .SW(SW),
        .LED(LED), .SEG(SEG), .AN(AN)
    );

    always #5 CLK = ~CLK;

    // external RAM: combinational read, write on clock edge
    assign ram_en  = MEM_CS & ~WE;
    assign Mem_Bus = tb_en ? tb_data : (ram_en ? ram[ADDR] : 32'bz);

    always @(posedge CLK) begin
        if (MEM_CS && WE) ram[ADDR] <= Mem_Bus;
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // digit shown after `cnt` clean cycles since reset: one digit per 2**DIV cycles
    function automatic int scan_digit(input int cnt);
        return (cnt / (2 ** DIV)) % 4;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a    = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_cnt <= 0;
            m_out <= 32'h0;
            m_rd  <= 8'h0;
            m_sw1 <= 8'h0;
            m_sw2 <= 8'h0;
            m_an  <= 4'b1110;
            m_seg <= 7'b1000000;
        end else begin
            m_an  <= an_of(scan_digit(m_cnt));
            m_seg <= hex7(4'((m_out >> (4 * scan_digit(m_cnt))) & 32'hF));
            if (CS && !WE && ADDR == IO_ADDR) m_rd <= m_sw2;
            if (CS && WE && ADDR == IO_ADDR) m_out <= Mem_Bus;
            m_sw2 <= m_sw1;
            m_sw1 <= SW;
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic idle();
        CS = 1'b0; WE = 1'b0; ADDR = 7'h0; tb_en = 1'b0; tb_data = 32'h0;
    endtask

    task automatic test_reset();
        RST = 1'b1; idle();
        @(negedge CLK);
        CS = 1'b1; WE = 1'b1; ADDR = IO_ADDR; tb_en = 1'b1; tb_data = 32'h0000_00FF;
        #1;
        checks++;
        if (MEM_CS !== 1'b0) begin errors++; $display("FAIL reset_memcs_io: got %b want 0", MEM_CS); end
        @(negedge CLK);
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL reset_write_override: LED got %h want 00", LED); end
        checks++;
        if (AN !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", AN); end
        checks++;
        if (SEG !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b want 1000000", SEG); end
        idle(); CS = 1'b1; ADDR = 7'h10;
        #1;
        checks++;
        if (MEM_CS !== 1'b1) begin errors++; $display("FAIL reset_memcs_ram: got %b want 1", MEM_CS); end
        idle(); RST = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_write_decode();
        CS = 1'b1; WE = 1'b1; ADDR = 7'h10; tb_en = 1'b1; tb_data = 32'h0000_A5C3;
        #1;
        checks++;
        if (MEM_CS !== 1'b1) begin errors++; $display("FAIL wr_ram_memcs: got %b want 1", MEM_CS); end
        @(negedge CLK);
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL wr_ram_led: got %h want 00", LED); end
        ADDR = IO_ADDR;
        #1;
        checks++;
        if (MEM_CS !== 1'b0) begin errors++; $display("FAIL wr_io_memcs: got %b want 0", MEM_CS); end
        @(negedge CLK);
        checks++;
        if (LED !== 8'hC3) begin errors++; $display("FAIL wr_io_led: got %h want c3", LED); end
        checks++;
        if (MEM_CS !== 1'b0) begin errors++; $display("FAIL wr_io_memcs_after: got %b want 0", MEM_CS); end
        ADDR = 7'h10; tb_data = 32'h0000_0077;
        @(negedge CLK);
        checks++;
        if (LED !== 8'hC3) begin errors++; $display("FAIL wr_ram_hold: got %h want c3", LED); end
        idle();
        $display("test_write_decode: LED=%h", LED);
    endtask

    task automatic test_read_path();
        SW = 8'h5A; idle();
        repeat (3) @(negedge CLK);
        CS = 1'b1; WE = 1'b0; ADDR = IO_ADDR;
        #1;
        checks++;
        if (MEM_CS !== 1'b0) begin errors++; $display("FAIL rd_memcs: got %b want 0", MEM_CS); end
        @(negedge CLK);
        checks++;
        if (Mem_Bus !== 32'h0000_005A) begin errors++; $display("FAIL rd_data: got %h want 0000005a", Mem_Bus); end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (Mem_Bus === 32'h0000_005A) begin errors++; $display("FAIL rd_release: bus still %h want Z", Mem_Bus); end
        $display("test_read_path: done");
    endtask

    task automatic test_sync();
        logic [31:0] got;
        SW = 8'h00; idle();
        repeat (3) @(negedge CLK);
        SW = 8'hFF; CS = 1'b1; WE = 1'b0; ADDR = IO_ADDR;
        @(negedge CLK);
        got = Mem_Bus;
        checks++;
        if (got !== 32'h0) begin errors++; $display("FAIL sync_late: got %h want 00000000", got); end
        idle(); SW = 8'h00;
        repeat (3) @(negedge CLK);
        SW = 8'hFF;
        repeat (2) @(negedge CLK);
        CS = 1'b1; WE = 1'b0; ADDR = IO_ADDR;
        @(negedge CLK);
        got = Mem_Bus;
        checks++;
        if (got !== 32'h0000_00FF) begin errors++; $display("FAIL sync_settled: got %h want 000000ff", got); end
        idle();
        $display("test_sync: settled read %h", got);
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        RST = 1'b1; idle();
        @(negedge CLK);
        RST = 1'b0; CS = 1'b1; WE = 1'b1; ADDR = IO_ADDR; tb_en = 1'b1; tb_data = 32'h0000_1234;
        @(negedge CLK);
        idle();
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            checks++;
            if (AN !== m_an || SEG !== m_seg) begin
                errors++; $display("FAIL scan_model k=%0d: AN=%b SEG=%b want %b %b", k, AN, SEG, m_an, m_seg);
            end
            if (k % 4 == 2) begin
                checks++;
                if (AN !== exp_an[k/4] || SEG !== exp_seg[k/4]) begin
                    errors++; $display("FAIL scan_digit%0d: AN=%b SEG=%b want %b %b", k/4, AN, SEG, exp_an[k/4], exp_seg[k/4]);
                end
                $display("scan k=%0d AN=%b SEG=%b", k, AN, SEG);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        CS = 1'b1; WE = 1'b1; ADDR = IO_ADDR; tb_en = 1'b1; tb_data = 32'h0000_FFFF;
        @(negedge CLK);
        idle();
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge CLK);
            if (scan_digit(m_cnt) == 2 && AN === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach_d2: timeout AN=%b want 1011", AN); end
        RST = 1'b1; CS = 1'b1; WE = 1'b1; ADDR = IO_ADDR; tb_en = 1'b1; tb_data = 32'h0000_0001;
        @(negedge CLK);
        RST = 1'b0; idle();
        checks++;
        if (LED !== 8'h00 || AN !== 4'b1110 || SEG !== 7'b1000000) begin
            errors++; $display("FAIL rstmid_state: LED=%h AN=%b SEG=%b want 00 1110 1000000", LED, AN, SEG);
        end
        @(negedge CLK);
        checks++;
        if (LED !== 8'h00 || AN !== 4'b1110 || SEG !== 7'b1000000) begin
            errors++; $display("FAIL rstmid_after: LED=%h AN=%b SEG=%b want 00 1110 1000000", LED, AN, SEG);
        end
        $display("test_reset_mid: LED=%h AN=%b SEG=%b", LED, AN, SEG);
    endtask

    task automatic test_random();
        int ncyc = 400;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            checks++;
            if (LED !== m_out[7:0] || AN !== m_an || SEG !== m_seg) begin
                errors++; $display("FAIL rand_regs i=%0d: LED=%h AN=%b SEG=%b want %h %b %b", i, LED, AN, SEG, m_out[7:0], m_an, m_seg);
            end
            RST     = ($urandom_range(0, 59) == 0);
            CS      = $urandom_range(0, 3) != 0;
            WE      = $urandom_range(0, 1) == 1;
            ADDR    = ($urandom_range(0, 1) == 1) ? IO_ADDR : 7'($urandom_range(0, 126));
            tb_data = $urandom;
            tb_en   = CS & WE;
            if ($urandom_range(0, 3) == 0) SW = 8'($urandom);
            #1;
            checks++;
            if (MEM_CS !== (CS && ADDR != IO_ADDR)) begin
                errors++; $display("FAIL rand_memcs i=%0d: got %b want %b", i, MEM_CS, CS && ADDR != IO_ADDR);
            end
            if (CS && !WE && ADDR == IO_ADDR) begin
                checks++;
                if (Mem_Bus !== {24'b0, m_rd}) begin
                    errors++; $display("FAIL rand_read i=%0d: got %h want %h", i, Mem_Bus, {24'b0, m_rd});
                end
            end
        end
        RST = 1'b0; idle();
        $display("test_random: %0d cycles", ncyc);
    endtask

    task automatic test_integration();
        logic [31:0] stored;
        logic [31:0] dest;
        logic [31:0] ram127;
        logic [7:0]  sw_val;
        ram127   = 32'hCAFE_0127;
        ram[127] = ram127;
        sw_val   = 8'($urandom);
        SW       = sw_val;
        stored   = $urandom;
        idle();
        repeat (3) @(negedge CLK);
        CS = 1'b1; WE = 1'b1; ADDR = 7'h7F; tb_en = 1'b1; tb_data = stored;
        @(negedge CLK);
        CS = 1'b1; WE = 1'b0; tb_en = 1'b0;
        @(negedge CLK);
        dest = Mem_Bus;
        @(negedge CLK);
        idle();
        checks++;
        if (LED !== stored[7:0]) begin errors++; $display("FAIL cpu_led: got %h want %h", LED, stored[7:0]); end
        checks++;
        if (dest !== {24'b0, sw_val}) begin errors++; $display("FAIL cpu_lw_io: got %h want %h", dest, {24'b0, sw_val}); end
        checks++;
        if (ram[127] !== ram127) begin errors++; $display("FAIL cpu_ram127: got %h want %h", ram[127], ram127); end
        CS = 1'b1; WE = 1'b1; ADDR = 7'h21; tb_en = 1'b1; tb_data = ~stored;
        @(negedge CLK);
        CS = 1'b1; WE = 1'b0; tb_en = 1'b0;
        @(negedge CLK);
        dest = Mem_Bus;
        idle();
        checks++;
        if (dest !== ~stored) begin errors++; $display("FAIL cpu_lw_ram: got %h want %h", dest, ~stored); end
        $display("test_integration: stored=%h sw=%h", stored, sw_val);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        test_reset();
        test_write_decode();
        test_read_path();
        test_sync();
        test_scan();
        test_reset_mid();
        test_random();
        test_integration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
